// File: rtl/sprite_pkg.sv
// sprite_pkg: shared colour type, flash colour and default palette-0 contents
// for the sprite palette bank.
package sprite_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t FLASH_COLOUR    = 12'hFFF;
  localparam int     DEFAULT_PAL_LEN = 8;

  // Palette 0 comes out of reset holding the classic sprite colours.
  localparam rgb12_t DEFAULT_PAL0 [DEFAULT_PAL_LEN] = '{
    12'h000, 12'h0E1, 12'hDA9, 12'h766,
    12'h421, 12'hB21, 12'h080, 12'hEEE
  };

  // Reset value of one palette entry: palette 0 gets the defaults, all else black.
  function automatic rgb12_t reset_entry(input int pal, input int idx);
    rgb12_t v;
    v = 12'h000;
    if ((pal == 0) && (idx < DEFAULT_PAL_LEN)) begin
      v = DEFAULT_PAL0[idx];
    end else begin
      v = 12'h000;
    end
    return v;
  endfunction

endpackage

// File: rtl/sprite_palette_bank_flash_timer.sv
// flash_timer: one per-palette hit-flash frame counter. A trigger (re)loads
// FLASH_FRAMES; each frame_start counts down to zero. A trigger in the same
// cycle as frame_start wins.
module flash_timer #(
  parameter int FLASH_FRAMES = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_frame_start,
  input  logic       i_trig,
  output logic [7:0] o_cnt,
  output logic       o_active
);

  localparam logic [7:0] LOAD_VAL = 8'(FLASH_FRAMES);

  logic [7:0] r_cnt;
  logic       r_active;
  logic [7:0] w_cnt_nxt;

  // Next count: load on trigger, otherwise decrement once per frame until zero.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_trig) begin
      w_cnt_nxt = LOAD_VAL;
    end else if (i_frame_start && (r_cnt != 8'd0)) begin
      w_cnt_nxt = r_cnt - 8'd1;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Counter and registered active flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= 8'd0;
      r_active <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_active <= (w_cnt_nxt != 8'd0);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_active = r_active;

endmodule

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: multi-palette, blank-time writable sprite colour lookup
// with a 2-stage read pipeline. The per-palette hit-flash effect is built only
// when SPRITE_PALETTE_FLASH_EN is defined; otherwise colours pass unmodified.
module sprite_palette_bank
  import sprite_pkg::*;
#(
  parameter  int IDX_W        = 3,
  parameter  int NUM_PAL      = 4,
  parameter  int FLASH_FRAMES = 8,
  localparam int PAL_W        = $clog2(NUM_PAL)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               blank,
  input  logic               rd_valid,
  input  logic [PAL_W-1:0]   pal_sel,
  input  logic [IDX_W-1:0]   index,
  output logic               out_valid,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               transparent,
  input  logic               wr_en,
  input  logic [PAL_W-1:0]   wr_pal,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [11:0]        wr_rgb,
  output logic               wr_ready,
  input  logic [NUM_PAL-1:0] flash_trig,
  output logic [NUM_PAL-1:0] flash_active
);

  localparam int             ENTRIES    = 1 << IDX_W;
  localparam logic [PAL_W:0] LP_NUM_PAL = (PAL_W + 1)'(NUM_PAL);

  rgb12_t            r_mem [NUM_PAL][ENTRIES];
  logic              w_wr_fire;
  logic              w_rd_in_range;
  rgb12_t            w_rd_word;

  logic              r_s1_valid;
  logic [PAL_W-1:0]  r_s1_pal;
  logic [IDX_W-1:0]  r_s1_idx;
  rgb12_t            r_s1_rgb;
  logic              r_s1_in_range;

  logic              w_flash_on;
  logic              w_s2_transp;
  rgb12_t            w_s2_rgb;

  // Writes are only accepted during blanking, so the pixel path never sees a torn update.
  assign wr_ready      = blank;
  assign w_wr_fire     = wr_en & blank & ({1'b0, wr_pal} < LP_NUM_PAL);
  assign w_rd_in_range = ({1'b0, pal_sel} < LP_NUM_PAL);

  // Palette register file: defaults on reset, one entry written per accepted write.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PAL; p++) begin
        for (int i = 0; i < ENTRIES; i++) begin
          r_mem[p][i] <= reset_entry(p, i);
        end
      end
    end else begin
      if (w_wr_fire) begin
        r_mem[wr_pal][wr_idx] <= wr_rgb;
      end
    end
  end

  // Addressed word; a palette number beyond NUM_PAL reads as black.
  always_comb begin
    w_rd_word = 12'h000;
    if (w_rd_in_range) begin
      w_rd_word = r_mem[pal_sel][index];
    end else begin
      w_rd_word = 12'h000;
    end
  end

  // Stage 1: capture the request and the pre-write contents of the entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_pal      <= {PAL_W{1'b0}};
      r_s1_idx      <= {IDX_W{1'b0}};
      r_s1_rgb      <= 12'h000;
      r_s1_in_range <= 1'b0;
    end else begin
      r_s1_valid    <= rd_valid;
      r_s1_pal      <= pal_sel;
      r_s1_idx      <= index;
      r_s1_rgb      <= w_rd_word;
      r_s1_in_range <= w_rd_in_range;
    end
  end

`ifdef SPRITE_PALETTE_FLASH_EN
  logic [7:0]         w_cnt [NUM_PAL];
  logic [NUM_PAL-1:0] w_active;

  for (genvar g = 0; g < NUM_PAL; g++) begin : g_flash
    flash_timer #(
      .FLASH_FRAMES (FLASH_FRAMES)
    ) u_flash_timer (
      .i_clk         (Clk),
      .i_rst_n       (Reset_n),
      .i_frame_start (frame_start),
      .i_trig        (flash_trig[g]),
      .o_cnt         (w_cnt[g]),
      .o_active      (w_active[g])
    );
  end

  assign flash_active = w_active;

  // Flash is on while the result's palette counter is nonzero and odd.
  always_comb begin
    w_flash_on = 1'b0;
    if (r_s1_in_range) begin
      w_flash_on = (w_cnt[r_s1_pal] != 8'd0) && w_cnt[r_s1_pal][0];
    end else begin
      w_flash_on = 1'b0;
    end
  end
`else
  logic w_unused_flash;
  assign w_unused_flash = ^{frame_start, flash_trig, r_s1_pal};
  assign flash_active   = {NUM_PAL{1'b0}};
  assign w_flash_on     = 1'b0;
`endif

  // Stage 2 colour: transparent pixels never flash.
  always_comb begin
    w_s2_transp = (!r_s1_in_range) || (r_s1_idx == {IDX_W{1'b0}});
    if (w_flash_on && !w_s2_transp) begin
      w_s2_rgb = FLASH_COLOUR;
    end else begin
      w_s2_rgb = r_s1_rgb;
    end
  end

  // Stage 2: registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid   <= 1'b0;
      red         <= 4'h0;
      green       <= 4'h0;
      blue        <= 4'h0;
      transparent <= 1'b0;
    end else begin
      out_valid   <= r_s1_valid;
      red         <= w_s2_rgb.r;
      green       <= w_s2_rgb.g;
      blue        <= w_s2_rgb.b;
      transparent <= w_s2_transp;
    end
  end

endmodule

// File: tb/tb_sprite_palette_bank.sv
// tb_sprite_palette_bank: table-driven lookups checked through a scoreboard,
// plus hand-written write, flash and reset sequences.
module tb_sprite_palette_bank;

  localparam int NUM_PAL      = 4;
  localparam int FLASH_FRAMES = 8;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic        blank;
  logic        rd_valid;
  logic [1:0]  pal_sel;
  logic [2:0]  index;
  logic        out_valid;
  logic [3:0]  red, green, blue;
  logic        transparent;
  logic        wr_en;
  logic [1:0]  wr_pal;
  logic [2:0]  wr_idx;
  logic [11:0] wr_rgb;
  logic        wr_ready;
  logic [3:0]  flash_trig;
  logic [3:0]  flash_active;

  sprite_palette_bank #(
    .IDX_W        (3),
    .NUM_PAL      (NUM_PAL),
    .FLASH_FRAMES (FLASH_FRAMES)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_start  (frame_start),
    .blank        (blank),
    .rd_valid     (rd_valid),
    .pal_sel      (pal_sel),
    .index        (index),
    .out_valid    (out_valid),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .transparent  (transparent),
    .wr_en        (wr_en),
    .wr_pal       (wr_pal),
    .wr_idx       (wr_idx),
    .wr_rgb       (wr_rgb),
    .wr_ready     (wr_ready),
    .flash_trig   (flash_trig),
    .flash_active (flash_active)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        tr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  pal;
    logic [2:0]  idx;
    logic [11:0] rgb;
    logic        tr;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic read(input logic [1:0] p, input logic [2:0] i, input logic [11:0] rgb, input logic tr);
    rd_valid = 1'b1;
    pal_sel  = p;
    index    = i;
    sb.push_back('{cyc + 2, rgb, tr});
    tick();
  endtask

  task automatic write(input logic [1:0] p, input logic [2:0] i, input logic [11:0] rgb);
    wr_en  = 1'b1;
    wr_pal = p;
    wr_idx = i;
    wr_rgb = rgb;
    check("wr_ready_follows_blank", wr_ready, blank);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    rd_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  // Output monitor: every valid result must match the oldest expectation at its due cycle.
  always @(negedge Clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("read_latency", cyc, e.due);
        check("read_rgb", {red, green, blue}, e.rgb);
        check("read_transparent", transparent, e.tr);
      end
    end else if ((sb.size() > 0) && (sb[0].due <= cyc)) begin
      check("missing_out_valid", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'd0, 3'd1, 12'h0E1, 1'b0};
    vecs[1]  = '{2'd0, 3'd2, 12'hDA9, 1'b0};
    vecs[2]  = '{2'd0, 3'd3, 12'h766, 1'b0};
    vecs[3]  = '{2'd0, 3'd4, 12'h421, 1'b0};
    vecs[4]  = '{2'd0, 3'd5, 12'hB21, 1'b0};
    vecs[5]  = '{2'd0, 3'd6, 12'h080, 1'b0};
    vecs[6]  = '{2'd0, 3'd7, 12'hEEE, 1'b0};
    vecs[7]  = '{2'd0, 3'd0, 12'h000, 1'b1};
    vecs[8]  = '{2'd1, 3'd3, 12'h000, 1'b0};
    vecs[9]  = '{2'd3, 3'd5, 12'h000, 1'b0};
    vecs[10] = '{2'd2, 3'd0, 12'h000, 1'b1};
    vecs[11] = '{2'd1, 3'd7, 12'h000, 1'b0};

    Reset_n     = 1'b0;
    frame_start = 1'b0;
    blank       = 1'b0;
    rd_valid    = 1'b0;
    pal_sel     = 2'd0;
    index       = 3'd0;
    wr_en       = 1'b0;
    wr_pal      = 2'd0;
    wr_idx      = 3'd0;
    wr_rgb      = 12'h000;
    flash_trig  = 4'b0000;
    tick();
    tick();

    // Reset state.
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_rgb", {red, green, blue}, 12'h000);
    check("reset_transparent", transparent, 1'b0);
    check("reset_flash_active", flash_active, 4'b0000);
    check("reset_wr_ready", wr_ready, 1'b0);
    blank = 1'b1;
    #1;
    check("wr_ready_comb", wr_ready, 1'b1);
    blank = 1'b0;
    Reset_n = 1'b1;
    tick();

    // Back-to-back lookups from the vector table.
    for (int v = 0; v < 12; v++) begin
      read(vecs[v].pal, vecs[v].idx, vecs[v].rgb, vecs[v].tr);
    end
    drain();

    // Write outside blanking is dropped; inside blanking it lands.
    write(2'd1, 3'd3, 12'hABC);
    read(2'd1, 3'd3, 12'h000, 1'b0);
    drain();
    blank = 1'b1;
    write(2'd1, 3'd3, 12'hABC);
    read(2'd1, 3'd3, 12'hABC, 1'b0);
    drain();

    // Same-cycle write and read of one entry returns the old value.
    wr_en  = 1'b1;
    wr_pal = 2'd0;
    wr_idx = 3'd5;
    wr_rgb = 12'h123;
    read(2'd0, 3'd5, 12'hB21, 1'b0);
    wr_en = 1'b0;
    read(2'd0, 3'd5, 12'h123, 1'b0);
    drain();
    blank = 1'b0;

`ifdef SPRITE_PALETTE_FLASH_EN
    // Palette 0 flash over FLASH_FRAMES frames.
    flash_trig = 4'b0001;
    tick();
    flash_trig = 4'b0000;
    check("flash_active_after_trig", flash_active, 4'b0001);
    for (int k = FLASH_FRAMES; k >= 1; k--) begin
      read(2'd0, 3'd7, ((k % 2) == 1) ? 12'hFFF : 12'hEEE, 1'b0);
      read(2'd0, 3'd0, 12'h000, 1'b1);
      rd_valid = 1'b0;
      tick();
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("flash_active_per_frame", flash_active[0], (k > 1));
    end
    read(2'd0, 3'd7, 12'hEEE, 1'b0);
    drain();
    check("flash_all_idle", flash_active, 4'b0000);

    // Palette 1: trigger coincident with frame_start at count 3 reloads.
    flash_trig = 4'b0010;
    tick();
    flash_trig = 4'b0000;
    repeat (5) frame();
    read(2'd1, 3'd3, 12'hFFF, 1'b0);
    drain();
    flash_trig  = 4'b0010;
    frame_start = 1'b1;
    tick();
    flash_trig  = 4'b0000;
    frame_start = 1'b0;
    read(2'd1, 3'd3, 12'hABC, 1'b0);
    drain();
    repeat (7) frame();
    check("retrig_load_wins_active", flash_active, 4'b0010);
    frame();
    check("retrig_expires", flash_active, 4'b0000);
`else
    // Flash logic absent: triggers are ignored.
    flash_trig  = 4'b1111;
    frame_start = 1'b1;
    tick();
    flash_trig  = 4'b0000;
    frame_start = 1'b0;
    check("flash_disabled_active", flash_active, 4'b0000);
    read(2'd0, 3'd7, 12'hEEE, 1'b0);
    read(2'd1, 3'd3, 12'hABC, 1'b0);
    drain();
    check("flash_disabled_still_idle", flash_active, 4'b0000);
`endif

    // Reset with results in flight and palette 0 entry 2 rewritten.
    blank = 1'b1;
    write(2'd0, 3'd2, 12'h555);
    read(2'd0, 3'd1, 12'h0E1, 1'b0);
    read(2'd0, 3'd2, 12'h555, 1'b0);
    check("out_valid_before_reset", out_valid, 1'b1);
    Reset_n  = 1'b0;
    rd_valid = 1'b0;
    sb.delete();
    #1;
    check("reset_flush_out_valid", out_valid, 1'b0);
    check("reset_flush_rgb", {red, green, blue}, 12'h000);
    tick();
    check("reset_hold_out_valid", out_valid, 1'b0);
    Reset_n = 1'b1;
    blank   = 1'b0;
    tick();
    check("out_valid_after_release", out_valid, 1'b0);
    read(2'd0, 3'd2, 12'hDA9, 1'b0);
    read(2'd0, 3'd5, 12'hB21, 1'b0);
    read(2'd1, 3'd3, 12'h000, 1'b0);
    drain();

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
